// File: rtl/irq_pending_ctrl.sv
// Interrupt pending/enable controller with per-source edge/level capture and
// lowest-index priority. Define IRQ_SYNC_EN to add a two-flop input synchroniser.
module irq_pending_ctrl #(
    parameter int                 NUM_SRC   = 16,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               csr_sel,
    input  logic [1:0]         csr_op,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    input  logic               claim,
    output logic               irq_req,
    output logic [4:0]         irq_id
);

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [NUM_SRC-1:0] src_s;
    logic [NUM_SRC-1:0] prev_q, prev_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic               irq_req_q, irq_req_d;
    logic [4:0]         irq_id_q, irq_id_d;

    logic [NUM_SRC-1:0] wr_bits;
    logic [NUM_SRC-1:0] pend_csr;
    logic [NUM_SRC-1:0] claim_clr;
    logic [NUM_SRC-1:0] edge_set;
    logic [NUM_SRC-1:0] active;

    function automatic logic [NUM_SRC-1:0] apply_op(input logic [1:0]         op,
                                                     input logic [NUM_SRC-1:0] cur,
                                                     input logic [NUM_SRC-1:0] wr);
        case (op)
            OP_WRITE: apply_op = wr;
            OP_SET:   apply_op = cur | wr;
            OP_CLEAR: apply_op = cur & ~wr;
            default:  apply_op = cur;
        endcase
    endfunction

    assign wr_bits = csr_wdata[NUM_SRC-1:0];

    generate
        if (NUM_SRC < 32) begin : g_wdata_hi
            // Operand bits above the implemented sources have no register behind them.
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^csr_wdata[31:NUM_SRC];
        end
    endgenerate

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = irq_src;
`endif

    always_comb begin
        pend_csr = pending_q;
        enable_d = enable_q;
        if (csr_sel) begin
            enable_d = apply_op(csr_op, enable_q, wr_bits);
        end else begin
            pend_csr = apply_op(csr_op, pending_q, wr_bits);
        end

        claim_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_clr[i] = claim && irq_req_q && (irq_id_q == 5'(i));
        end

        edge_set = src_s & ~prev_q;
        prev_d   = src_s;
        // A fresh edge beats a same-cycle CSR clear or claim; level bits just follow the line.
        pending_d = (EDGE_MASK & ((pend_csr & ~claim_clr) | edge_set))
                  | (~EDGE_MASK & src_s);
    end

    always_comb begin
        active    = pending_q & enable_q;
        irq_req_d = 1'b0;
        irq_id_d  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                irq_req_d = 1'b1;
                irq_id_d  = 5'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            irq_req_q <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            irq_req_q <= irq_req_d;
            irq_id_q  <= irq_id_d;
        end
    end

    assign csr_rdata = csr_sel ? 32'(enable_q) : 32'(pending_q);
    assign irq_req   = irq_req_q;
    assign irq_id    = irq_id_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: a CSR/claim vector table followed by
// hand-written source, level, edge-vs-clear and reset sequences.
module tb_irq_pending_ctrl;

    localparam int NUM_SRC = 16;
`ifdef IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_SRC-1:0] irq_src;
    logic               csr_sel;
    logic [1:0]         csr_op;
    logic [31:0]        csr_wdata;
    logic [31:0]        csr_rdata;
    logic               claim;
    logic               irq_req;
    logic [4:0]         irq_id;

    int checks = 0;
    int errors = 0;

    // Source 2 is level-triggered, every other source is edge-triggered.
    irq_pending_ctrl #(
        .NUM_SRC  (NUM_SRC),
        .EDGE_MASK(16'hFFFB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_src  (irq_src),
        .csr_sel  (csr_sel),
        .csr_op   (csr_op),
        .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata),
        .claim    (claim),
        .irq_req  (irq_req),
        .irq_id   (irq_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic        claim;
        logic [31:0] exp_rdata;
        logic        exp_req;
        logic [4:0]  exp_id;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic sel, input logic [1:0] op, input logic [31:0] wdata,
                                input logic clm, input logic [31:0] rd, input logic req,
                                input logic [4:0] id);
        vec_t v;
        v.sel = sel; v.op = op; v.wdata = wdata; v.claim = clm;
        v.exp_rdata = rd; v.exp_req = req; v.exp_id = id;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string name, input logic sel, input logic [31:0] exp);
        csr_sel = sel;
        #1;
        chk(name, csr_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Pre-edge expectations: rdata shows the register before this row's op lands.
        tbl[0]  = mk(1'b1, 2'b00, 32'h0,        1'b0, 32'h0000_0000, 1'b0, 5'd0);
        tbl[1]  = mk(1'b1, 2'b01, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 5'd0);
        tbl[2]  = mk(1'b1, 2'b00, 32'h0,        1'b0, 32'h0000_FFFF, 1'b0, 5'd0);
        tbl[3]  = mk(1'b1, 2'b11, 32'h0000_FDF7, 1'b0, 32'h0000_FFFF, 1'b0, 5'd0);
        tbl[4]  = mk(1'b1, 2'b00, 32'h0,        1'b0, 32'h0000_0208, 1'b0, 5'd0);
        tbl[5]  = mk(1'b0, 2'b10, 32'h0000_0204, 1'b0, 32'h0000_0000, 1'b0, 5'd0);
        tbl[6]  = mk(1'b0, 2'b00, 32'h0,        1'b0, 32'h0000_0200, 1'b0, 5'd0);
        tbl[7]  = mk(1'b0, 2'b10, 32'h0000_0008, 1'b0, 32'h0000_0200, 1'b1, 5'd9);
        tbl[8]  = mk(1'b0, 2'b00, 32'h0,        1'b0, 32'h0000_0208, 1'b1, 5'd9);
        tbl[9]  = mk(1'b0, 2'b00, 32'h0,        1'b1, 32'h0000_0208, 1'b1, 5'd3);
        tbl[10] = mk(1'b0, 2'b00, 32'h0,        1'b0, 32'h0000_0200, 1'b1, 5'd3);
        tbl[11] = mk(1'b0, 2'b00, 32'h0,        1'b0, 32'h0000_0200, 1'b1, 5'd9);
        tbl[12] = mk(1'b0, 2'b01, 32'h0,        1'b0, 32'h0000_0200, 1'b1, 5'd9);
        tbl[13] = mk(1'b0, 2'b00, 32'h0,        1'b0, 32'h0000_0000, 1'b1, 5'd9);
        tbl[14] = mk(1'b0, 2'b00, 32'h0,        1'b0, 32'h0000_0000, 1'b0, 5'd0);

        rst = 1'b1; irq_src = '0; csr_sel = 1'b0; csr_op = 2'b00; csr_wdata = '0; claim = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("reset_irq_req", 32'(irq_req), 32'h0);
        chk("reset_irq_id", 32'(irq_id), 32'h0);
        rd_chk("reset_pending", 1'b0, 32'h0);
        rd_chk("reset_enable", 1'b1, 32'h0);
        tick();
        rst = 1'b0;

        for (int r = 0; r < 15; r++) begin
            csr_sel = tbl[r].sel; csr_op = tbl[r].op; csr_wdata = tbl[r].wdata; claim = tbl[r].claim;
            @(negedge clk);
            chk($sformatf("tbl%0d_rdata", r), csr_rdata, tbl[r].exp_rdata);
            chk($sformatf("tbl%0d_req", r), 32'(irq_req), 32'(tbl[r].exp_req));
            chk($sformatf("tbl%0d_id", r), 32'(irq_id), 32'(tbl[r].exp_id));
            tick();
        end
        csr_op = 2'b00; claim = 1'b0; csr_wdata = '0;

        // Single-cycle pulse on edge source 5 with every source enabled.
        csr_sel = 1'b1; csr_op = 2'b01; csr_wdata = 32'h0000_FFFF;
        tick();
        csr_op = 2'b00; csr_sel = 1'b0;
        irq_src[5] = 1'b1;
        tick();
        irq_src[5] = 1'b0;
        for (int k = 0; k < LAT - 2; k++) tick();
        @(negedge clk);
        chk("pulse5_req_early", 32'(irq_req), 32'h0);
        tick();
        @(negedge clk);
        chk("pulse5_req", 32'(irq_req), 32'h1);
        chk("pulse5_id", 32'(irq_id), 32'd5);
        rd_chk("pulse5_pending", 1'b0, 32'h0000_0020);
        tick();
        claim = 1'b1;
        tick();
        claim = 1'b0;
        @(negedge clk);
        rd_chk("pulse5_claimed", 1'b0, 32'h0);
        tick();
        @(negedge clk);
        chk("pulse5_req_drop", 32'(irq_req), 32'h0);

        // Level source 2 ignores a CSR clear and follows the line when it drops.
        tick();
        irq_src[2] = 1'b1;
        for (int k = 0; k < LAT; k++) tick();
        @(negedge clk);
        chk("level2_req", 32'(irq_req), 32'h1);
        chk("level2_id", 32'(irq_id), 32'd2);
        tick();
        csr_sel = 1'b0; csr_op = 2'b11; csr_wdata = 32'h0000_0004;
        tick();
        csr_op = 2'b00; csr_wdata = '0;
        @(negedge clk);
        rd_chk("level2_after_clear", 1'b0, 32'h0000_0004);
        tick();
        irq_src[2] = 1'b0;
        for (int k = 0; k < LAT - 1; k++) tick();
        @(negedge clk);
        rd_chk("level2_pending_drop", 1'b0, 32'h0);
        chk("level2_req_lag", 32'(irq_req), 32'h1);
        tick();
        @(negedge clk);
        chk("level2_req_drop", 32'(irq_req), 32'h0);

        // Edge source 7 detected in the same cycle as a CSR clear of bit 7.
        tick();
        irq_src[7] = 1'b1;
        for (int k = 0; k < LAT - 2; k++) tick();
        csr_sel = 1'b0; csr_op = 2'b11; csr_wdata = 32'h0000_0080;
        tick();
        csr_op = 2'b00; csr_wdata = '0;
        @(negedge clk);
        rd_chk("edge7_wins_clear", 1'b0, 32'h0000_0080);
        tick();
        @(negedge clk);
        chk("edge7_req", 32'(irq_req), 32'h1);
        chk("edge7_id", 32'(irq_id), 32'd7);

        // Asynchronous reset mid-cycle, then a CSR write presented under reset.
        rst = 1'b1;
        #1;
        chk("rst_async_req", 32'(irq_req), 32'h0);
        chk("rst_async_id", 32'(irq_id), 32'h0);
        rd_chk("rst_async_pending", 1'b0, 32'h0);
        rd_chk("rst_async_enable", 1'b1, 32'h0);
        csr_sel = 1'b1; csr_op = 2'b01; csr_wdata = 32'h0000_FFFF;
        tick();
        rst = 1'b0; csr_op = 2'b00; csr_wdata = '0;
        // Source 7 is still high, so it registers as a fresh edge after release.
        for (int k = 0; k < LAT - 1; k++) tick();
        @(negedge clk);
        rd_chk("post_rst_enable", 1'b1, 32'h0);
        rd_chk("post_rst_edge7", 1'b0, 32'h0000_0080);
        chk("post_rst_req", 32'(irq_req), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_pending_ctrl.md
IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 16: number of interrupt sources; legal range 1..32.
REQ-002 SHALL have parameter EDGE_MASK, default {NUM_SRC{1'b0}}: bit i=1 makes source i edge-triggered, 0 makes it level-triggered.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port irq_src  input  NUM_SRC: raw interrupt source lines.
REQ-006 SHALL have port csr_sel  input  1: 0 = pending register, 1 = enable register.
REQ-007 SHALL have port csr_op  input  2: 00 none, 01 write, 10 set-bits, 11 clear-bits.
REQ-008 SHALL have port csr_wdata  input  32: CSR write operand.
REQ-009 SHALL have port csr_rdata  output  32: selected register, zero-extended.
REQ-010 SHALL have port claim  input  1: core acknowledges the currently presented interrupt.
REQ-011 SHALL have port irq_req  output  1: registered interrupt request.
REQ-012 SHALL have port irq_id  output  5: registered index of the presented source.

Function
REQ-013 SHALL hold pending[NUM_SRC-1:0] and enable[NUM_SRC-1:0] registers.
REQ-014 SHALL, for an edge source, set pending[i] on the cycle where the sampled source is 1 and the previously sampled value is 0.
REQ-015 SHALL, for a level source, load pending[i] from the sampled source every cycle; CSR and claim effects on level bits are ignored.
REQ-016 SHALL compute the edge-source next value as ((pending after CSR op) & ~claim_clear) | edge_set: a new edge always wins over a same-cycle clear.
REQ-017 SHALL apply CSR ops to enable the same way (write: load; set: OR; clear: AND-NOT); with csr_op=00 the registers are unchanged.
REQ-018 SHALL ignore csr_wdata bits at index >= NUM_SRC and read them back as 0.
REQ-019 SHALL drive csr_rdata combinationally from the current (pre-update) value of the selected register.
REQ-020 SHALL select the lowest-index bit of pending & enable as winner; irq_req/irq_id register winner-valid/index one cycle later.
REQ-021 SHALL, when no bit is active, register irq_req=0 and irq_id=0.
REQ-022 SHALL, on claim=1 with irq_req=1, clear pending[irq_id] if that source is edge-type; claim with irq_req=0 has no effect.
REQ-023 SHALL yield a latency of 2 cycles from source rising at the sample point to irq_req=1 (pending update, then output register), with the enable bit set.

Reset
REQ-024 SHALL, while rst=1, force pending, enable, previous-sample register, synchroniser flops, irq_req and irq_id to 0 immediately, independent of clk.
REQ-025 SHALL treat a source already at 1 on the first cycle after reset release as an edge, because the previous sample resets to 0.
REQ-026 SHALL discard any CSR op or claim presented in the cycle rst is asserted.

Configuration
REQ-027 SHALL, with IRQ_SYNC_EN defined, pass each irq_src bit through a two-flop synchroniser before edge or level detection, making REQ-023 latency 4 cycles.
REQ-028 SHALL, without IRQ_SYNC_EN, sample irq_src directly with 2-cycle latency; all other behaviour is identical.

Verification
REQ-029 SHALL check: NUM_SRC=16, enable=0xFFFF, pulse irq_src[5] one cycle -> irq_req=1, irq_id=5 two cycles later (four with IRQ_SYNC_EN); pending reads 0x0020.
REQ-030 SHALL check: pending bits 3 and 9 set, enable=0x0208 -> irq_id=3; claim -> pending=0x0200, irq_id=9 next cycle.
REQ-031 SHALL check: level source 2 held high, csr clear-bits 0x0004 on pending -> pending[2] stays 1; source drops -> pending[2]=0 next cycle, irq_req falls one cycle later.
REQ-032 SHALL check: edge source 7 rises in the same cycle as csr clear-bits 0x0080 on pending -> pending[7]=1 afterwards.
REQ-033 SHALL check: csr write 0xFFFFFFFF to enable with NUM_SRC=16 -> csr_rdata reads 0x0000FFFF.
REQ-034 SHALL check: rst asserted mid-cycle while irq_req=1 -> irq_req, irq_id, pending and enable read 0 before the next clk edge.
